// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine.
//   led_mode_t : 2-bit pattern mode selector
//   MODE_*     : mode encodings (rotate left/right, bounce, fill/drain)
package led_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t MODE_ROL    = 2'b00;
  localparam led_mode_t MODE_ROR    = 2'b01;
  localparam led_mode_t MODE_BOUNCE = 2'b10;
  localparam led_mode_t MODE_FILL   = 2'b11;

  // Pattern a mode starts from after a mode change: fill/drain starts dark,
  // every other mode starts with bit 0 lit.
  function automatic logic init_is_dark(led_mode_t mode);
    return mode == MODE_FILL;
  endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle of the LED pattern engine.
//   en       : run prescaler and pattern (0 = freeze)
//   mode     : pattern mode (see led_pkg)
//   load     : single-cycle synchronous pattern load strobe
//   load_val : pattern written on load
//   led      : registered LED pattern
//   step     : one-cycle pulse after each tick-driven advance
//   dir      : bounce/fill phase, 0 = left/fill, 1 = right/drain
// master drives the controls, slave is the engine.
interface led_pattern_engine_if
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);

  logic             en;
  led_mode_t        mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] led;
  logic             step;
  logic             dir;

  modport master (
    output en, mode, load, load_val,
    input  led, step, dir
  );

  modport slave (
    input  en, mode, load, load_val,
    output led, step, dir
  );

endinterface

// File: rtl/led_pattern_engine_tick_prescaler.sv
// Prescaler producing one tick every DIV enabled cycles.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   en   : count enable (0 = hold)
//   clr  : synchronous clear, wins over counting
//   tick : high in the enabled cycle where the count reaches DIV-1
module tick_prescaler #(
  parameter int unsigned DIV   = 5000000,
  parameter int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = en && (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: advances the LED bank one step per prescaler tick in
// one of four modes (rotate left, rotate right, bounce, fill/drain).
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : control/status bundle (en, mode, load, load_val in; led, step, dir out)
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 5000000,
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  led_pattern_engine_if.slave   bus
);

  logic [WIDTH-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  led_mode_t        mode_q;

  logic             mode_chg;
  logic             tick;
  logic [WIDTH-1:0] fill_next;

  assign mode_chg = (bus.mode != mode_q);

  tick_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load | mode_chg),
    .tick (tick)
  );

  // Fill shifts in ones while filling and zeros while draining.
  assign fill_next = {led_q[WIDTH-2:0], ~dir_q};

  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (bus.load) begin
      led_d = bus.load_val;
      dir_d = 1'b0;
    end else if (mode_chg) begin
      led_d = init_is_dark(bus.mode) ? '0 : WIDTH'(1);
      dir_d = 1'b0;
    end else if (tick) begin
      step_d = 1'b1;
      unique case (mode_q)
        MODE_ROL: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        MODE_ROR: led_d = {led_q[0], led_q[WIDTH-1:1]};
        MODE_BOUNCE: begin
          // Turn around on the step leaving an end LED so it is shown once.
          if (!dir_q) begin
            if (led_q[WIDTH-1]) begin
              dir_d = 1'b1;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = 1'b0;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        MODE_FILL: begin
          led_d = fill_next;
          if (!dir_q && (&fill_next)) begin
            dir_d = 1'b1;
          end else if (dir_q && !(|fill_next)) begin
            dir_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q  <= WIDTH'(1);
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      mode_q <= MODE_ROL;
    end else begin
      led_q  <= led_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      mode_q <= bus.mode;
    end
  end

  assign bus.led  = led_q;
  assign bus.step = step_q;
  assign bus.dir  = dir_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;
  import led_pkg::*;

  localparam int W   = 8;
  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst1;

  led_pattern_engine_if #(.WIDTH(W)) bus ();
  led_pattern_engine_if #(.WIDTH(W)) bus1 ();

  led_pattern_engine #(.WIDTH(W), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  led_pattern_engine #(.WIDTH(W), .DIV(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  typedef struct packed {
    logic [W-1:0] led;
    logic         step;
    logic         dir;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state.
  logic [W-1:0] m_led;
  logic         m_dir;
  int           m_cnt;
  led_mode_t    m_mode_q;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected observation per clocked cycle.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led", 32'(bus.led), 32'(e.led));
      check("step", 32'(bus.step), 32'(e.step));
      check("dir", 32'(bus.dir), 32'(e.dir));
    end
  end

  task automatic model_reset();
    m_led    = 8'h01;
    m_dir    = 1'b0;
    m_cnt    = 0;
    m_mode_q = MODE_ROL;
  endtask

  // Applies the rules to the inputs seen at this clock edge.
  task automatic model_clock();
    obs_t o;
    bit   stp;
    int   v;
    stp = 1'b0;
    if (bus.load) begin
      m_led = bus.load_val;
      m_dir = 1'b0;
      m_cnt = 0;
    end else if (bus.mode != m_mode_q) begin
      m_led = (bus.mode == MODE_FILL) ? 8'h00 : 8'h01;
      m_dir = 1'b0;
      m_cnt = 0;
    end else if (bus.en) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        stp   = 1'b1;
        v     = int'(m_led);
        case (m_mode_q)
          MODE_ROL: m_led = 8'((v * 2) % 256 + v / 128);
          MODE_ROR: m_led = 8'(v / 2 + (v % 2) * 128);
          MODE_BOUNCE: begin
            if (!m_dir && v >= 128) m_dir = 1'b1;
            else if (m_dir && (v % 2) == 1) m_dir = 1'b0;
            m_led = m_dir ? 8'(v / 2) : 8'((v * 2) % 256);
          end
          default: begin
            m_led = 8'((v * 2) % 256 + (m_dir ? 0 : 1));
            if (!m_dir && m_led == 8'hFF) m_dir = 1'b1;
            else if (m_dir && m_led == 8'h00) m_dir = 1'b0;
          end
        endcase
      end else begin
        m_cnt++;
      end
    end
    m_mode_q = bus.mode;
    o.led  = m_led;
    o.step = stp;
    o.dir  = m_dir;
    exp_q.push_back(o);
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cyc(bit e, led_mode_t md, bit ld = 1'b0, logic [W-1:0] v = '0);
    bus.en       = e;
    bus.mode     = md;
    bus.load     = ld;
    bus.load_val = v;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    #1;
  endtask

  task automatic mid_reset();
    rst = 1'b0;
    #1;
    check("rst_led", 32'(bus.led), 32'h01);
    check("rst_step", 32'(bus.step), 32'h0);
    check("rst_dir", 32'(bus.dir), 32'h0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    led_mode_t md;
    bit        ld;
    rst           = 1'b0;
    rst1          = 1'b0;
    bus.en        = 1'b0;
    bus.mode      = MODE_ROL;
    bus.load      = 1'b0;
    bus.load_val  = '0;
    bus1.en       = 1'b1;
    bus1.mode     = MODE_ROL;
    bus1.load     = 1'b0;
    bus1.load_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_led", 32'(bus.led), 32'h01);
    check("reset_step", 32'(bus.step), 32'h0);
    check("reset_dir", 32'(bus.dir), 32'h0);
    rst = 1'b1;

    repeat (40) cyc(1'b1, MODE_ROL);
    repeat (64) cyc(1'b1, MODE_BOUNCE);
    repeat (72) cyc(1'b1, MODE_FILL);

    // Pause mid-count in rotate-right.
    repeat (9) cyc(1'b1, MODE_ROR);
    for (int i = 0; i < 8 && m_cnt != 1; i++) cyc(1'b1, MODE_ROR);
    repeat (10) cyc(1'b0, MODE_ROR);
    repeat (12) cyc(1'b1, MODE_ROR);

    // Load on a tick cycle.
    for (int i = 0; i < 8 && m_cnt != DIV - 1; i++) cyc(1'b1, MODE_ROR);
    cyc(1'b1, MODE_ROR, 1'b1, 8'hA5);
    repeat (8) cyc(1'b1, MODE_ROR);
    cyc(1'b0, MODE_ROR, 1'b1, 8'h5A);
    repeat (3) cyc(1'b0, MODE_ROR);

    // Mode change 00 -> 11 at 0x10, then the same with a load.
    for (int i = 0; i < 60 && m_led != 8'h10; i++) cyc(1'b1, MODE_ROL);
    cyc(1'b1, MODE_FILL);
    repeat (10) cyc(1'b1, MODE_FILL);
    for (int i = 0; i < 60 && m_led != 8'h10; i++) cyc(1'b1, MODE_ROL);
    cyc(1'b1, MODE_FILL, 1'b1, 8'h3C);
    repeat (10) cyc(1'b1, MODE_FILL);

    // Mid-run reset, then randomized traffic.
    mid_reset();
    repeat (10) cyc(1'b1, MODE_FILL);
    md = MODE_BOUNCE;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) md = led_mode_t'($urandom_range(0, 3));
      ld = ($urandom_range(0, 39) == 0);
      cyc(($urandom_range(0, 9) != 0), md, ld, W'($urandom));
      if (i == 400) mid_reset();
    end
    check("drain", 32'(exp_q.size()), 32'h0);

    // DIV = 1: advances every enabled cycle, step stays high.
    rst1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic [W-1:0] one;
      logic [W-1:0] exp_led;
      @(negedge clk);
      one     = 8'h01;
      exp_led = one << (k % W);
      check("div1_led", 32'(bus1.led), 32'(exp_led));
      check("div1_step", 32'(bus1.step), 32'h1);
    end
    @(posedge clk);
    #2;
    rst1 = 1'b0;
    #1;
    check("async_led", 32'(bus1.led), 32'h01);
    check("async_step", 32'(bus1.step), 32'h0);
    check("async_dir", 32'(bus1.dir), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised LED pattern generator driving the board LED bank from a free-running clock.
- A prescaler produces one step tick every DIV enabled cycles. The pattern register advances one step per tick in one of four run-time-selectable modes: rotate left, rotate right, bounce, and fill/drain.
- Supports pause, synchronous pattern load and a per-step strobe for downstream logic (e.g. 7-seg or debug counters).

Parameters:
- WIDTH, 16, number of LEDs (≥ 2)
- DIV, 5000000, enabled clock cycles per pattern step (≥ 1)
- CNT_W, $clog2(DIV) (min 1), prescaler counter width; derived, not to be overridden

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- en  in  1  1 = run prescaler and pattern; 0 = freeze both
- mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 fill/drain
- load  in  1  single-cycle synchronous load strobe
- load_val  in  WIDTH  pattern written on load
- led  out  WIDTH  LED pattern, registered
- step  out  1  one-cycle pulse in the cycle after the pattern advances; registered
- dir  out  1  current bounce/fill phase: 0 = left/fill, 1 = right/drain; registered

Behaviour:
- Reset (rst = 0, asynchronous) sets:
  - led = 1 (bit 0 lit)
  - count = 0, step = 0, dir = 0
  - mode_q = 2'b00
- Prescaler:
  - When en = 1, count increments each cycle.
  - tick = en && (count == DIV-1). On tick, count wraps to 0.
  - Step period is exactly DIV cycles. DIV = 1 means tick on every enabled cycle.
- Pause: en = 0 holds count, led and dir. step = 0.
- Mode change:
  - mode_q registers mode every cycle.
  - When mode != mode_q (a change) and load = 0: count <= 0, dir <= 0, and led is reinitialised to 1 for modes 00/01/10, or to 0 for mode 11.
  - No step occurs in that cycle, regardless of en.
- Load:
  - load = 1 sets led <= load_val, count <= 0, dir <= 0. No step in that cycle.
  - Load has priority over a mode change and over tick.
  - load is honoured even when en = 0.
- Step rules, on tick with no load and no mode change (W = WIDTH):
  - 00: led <= {led[W-2:0], led[W-1]}
  - 01: led <= {led[0], led[W-1:1]}
  - 10:
    - if dir = 0: if led[W-1] then {dir <= 1; shift right} else shift left.
    - if dir = 1: if led[0] then {dir <= 0; shift left} else shift right.
    - Shifts are logical, zero-fill.
    - One-hot period = 2W-2 steps; the end LED is never shown twice in succession.
  - 11:
    - if dir = 0: led <= {led[W-2:0], 1'b1}; set dir <= 1 when the result is all-ones.
    - if dir = 1: led <= {led[W-2:0], 1'b0}; set dir <= 0 when the result is all-zeros.
    - Period = 2W steps.
- step:
  - Registered copy of "pattern advanced this cycle", i.e. high for exactly one cycle following each tick-driven update.
  - Never high following a load or a mode reinit.
- Arithmetic: count compare uses the full CNT_W width; no overflow is possible because count < DIV always.
- Reset mid-run: everything returns to reset values immediately. After rst deasserts, the first step occurs DIV enabled cycles later.
- Unused mode encodings: none; all four are defined.

Decomposition:
- Shared package led_pkg:
  - mode encoding constants MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_FILL
  - 2-bit typedef led_mode_t
- One natural sub-module: tick_prescaler (parameters DIV, CNT_W; ports clk, rst, en, clr, tick).
  - Reusable by other timer-driven blocks.
  - clr is driven by load | mode-change.
- Pattern/next-state logic stays in led_pattern_engine.

Test Plan (WIDTH = 8, DIV = 4 unless noted):
- Reset then mode 00, en = 1 for 40 cycles -> led 0x01, 0x02, 0x04 ... 0x80, 0x01, changing every 4 cycles. step pulses 4 cycles apart. First change 4 cycles after reset release.
- Mode 10, en = 1 -> led sequence 0x01, 0x02 ... 0x80, 0x40 ... 0x01, 0x02 (period 14 steps). dir goes to 1 on the step leaving 0x80 and back to 0 on the step leaving 0x01.
- Mode 11 -> 0x00, 0x01, 0x03 ... 0xFF, 0xFE, 0xFC ... 0x00, 0x01 (period 16). dir = 1 while draining.
- Pause/load:
  - Mode 01: drop en mid-count for 10 cycles -> led and count frozen, no step; resume continues the remaining count.
  - Pulse load with load_val = 0xA5 on a tick cycle -> led = 0xA5, no step that cycle, next step DIV cycles later gives 0xD2.
- Mode change 00 -> 11 while led = 0x10 -> next cycle led = 0x00, count = 0, dir = 0. Same cycle with load = 1 and load_val = 0x3C -> led = 0x3C instead.
- DIV = 1, mode 00 -> led advances every enabled cycle and step is high continuously. Assert rst asynchronously mid-cycle -> led = 0x01, step = 0 immediately, without waiting for a clock edge.
